seq_addsub: RTL and testbench
=============================

Name: seq_addsub

Overview:
- Parametrised multi-cycle adder/subtractor. Processes a WIDTH-bit operand pair CHUNK bits per clock through a single CHUNK-bit ripple slice.
- Carry/borrow is held in a flop between slices.
- Successor to the fixed 4-bit ripple adder. Adds generic width, runtime add/sub mode, valid/ready handshakes and status flags.
- Sits between operand registers and the result bus in the arithmetic datapath.

Parameters:
- WIDTH, 16: operand and result width in bits. Must be a multiple of CHUNK and ≥ CHUNK.
- CHUNK, 4: bits processed per cycle. NCH = WIDTH/CHUNK cycles per operation.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0 = A+B, 1 = A−B. Sampled with the operands.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- carry  out  1  carry out for add. For sub it is the inverted borrow: 1 when A ≥ B unsigned.
- overflow  out  1  two's-complement signed overflow.
- zero  out  1  sum == 0.

Behaviour:
- Reset: state IDLE. in_ready=1, out_valid=0, sum=0, carry=0, overflow=0, zero=0. Internal registers cleared.
- rst has priority over all other inputs in every state. Reset during RUN or DONE aborts the operation and discards the result.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1 at a rising edge (accept edge):
    - latch A into shift reg SA, and B XOR {WIDTH{sub}} into SB;
    - carry flop c = sub;
    - chunk counter k = 0;
    - go to RUN.
  - in_ready is 0 in RUN and DONE. There is no overlap of operations.
- RUN: each edge computes {c', s} = SA[CHUNK-1:0] + SB[CHUNK-1:0] + c (CHUNK+1 bits).
  - s shifts into the result register from the MSB side. SA and SB shift right by CHUNK.
  - c ← c'; k ← k+1.
  - On the edge where k == NCH−1:
    - go to DONE and set out_valid=1;
    - carry = final c';
    - overflow = carry into MSB XOR carry out of MSB, using the internal MSB carry of the last slice;
    - zero = (final sum == 0).
- Latency: out_valid rises exactly NCH edges after the accept edge. For WIDTH=16, CHUNK=4 this is 4 edges.
- DONE:
  - sum, carry, overflow and zero are held stable while out_valid=1.
  - On out_ready=1 at an edge: out_valid ← 0 and go to IDLE. Outputs keep their last values after that.
  - Back-to-back: new operands can be accepted at the edge after the result handshake. Throughput is one operation per NCH+2 cycles with out_ready held high.
  - out_ready while not in DONE has no effect.
- a, b and sub are don't-care outside the accept edge. Changing them during RUN does not affect the result.
- Arithmetic is modulo 2^WIDTH. Wrap-around is reported via carry/overflow only, except as described under Optional Feature.
- CHUNK == WIDTH is legal: a single-cycle slice, NCH = 1.

Optional Feature:
- Macro: SEQ_ADDSUB_SAT_EN.
- Defined: sum saturates as signed when overflow=1.
  - Positive overflow gives 0111…1. Negative overflow gives 1000…0.
  - overflow still reports 1. carry is unchanged. zero is computed on the saturated value.
  - Saturation is applied on the final RUN edge; latency is unchanged.
- Undefined: sum is the wrapped modulo result. No saturation logic is synthesised.

Test Plan:
- WIDTH=16, CHUNK=4. Add 0x1234 + 0x0FCD, sub=0 → after 4 edges: sum=0x2201, carry=0, overflow=0, zero=0. in_ready low for 5 cycles when out_ready is held high.
- Sub 0x0005 − 0x0007, sub=1 → sum=0xFFFE, carry=0 (borrow), overflow=0. Then 0x0007 − 0x0007 → sum=0x0000, carry=1, zero=1.
- Signed overflow: 0x7FFF + 0x0001 → sum=0x8000, overflow=1, carry=0. With SEQ_ADDSUB_SAT_EN defined, sum=0x7FFF. Also 0x8000 − 0x0001 → sum=0x7FFF without the macro, 0x8000 with it; overflow=1 in both cases.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → sum and flags stable, in_ready=0 and new in_valid ignored. Raise out_ready → IDLE next edge, then accept the next pair.
- Reset mid-operation: assert rst on the 2nd RUN edge → next cycle state is IDLE, in_ready=1, out_valid=0, sum=0. A subsequent 0xFFFF + 0x0001 yields sum=0x0000, carry=1, zero=1.
- Parameter sweep: WIDTH=8/CHUNK=8 and WIDTH=32/CHUNK=1 → latency is 1 and 32 edges respectively. Random operands match the reference model for sum, carry, overflow and zero.

Source files
------------

// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle adder/subtractor built around one CHUNK-bit ripple
// slice. A WIDTH-bit operand pair is processed LSB-first, CHUNK bits per
// clock, and the carry/borrow is held in a flop between slices.
//
// Optional feature macro: SEQ_ADDSUB_SAT_EN
//   defined   -> sum saturates as a signed value when overflow is flagged
//   undefined -> sum is the wrapped modulo-2^WIDTH result
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one CHUNK-bit slice processed per clock
// DONE  | result and flags held, out_valid=1 until out_ready
module seq_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             c_q, c_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [CHUNK:0]   slice_full;
  logic [CHUNK-1:0] slice_s;
  logic             slice_cout;
  logic             msb_cin;
  logic             slice_ovf;
  logic [WIDTH-1:0] res_shift;
  logic [WIDTH-1:0] final_sum;

  // Ripple slice on the low chunk plus the result value it would produce.
  always_comb begin
    slice_full = {1'b0, sa_q[CHUNK-1:0]} + {1'b0, sb_q[CHUNK-1:0]}
               + (CHUNK+1)'(c_q);
    slice_s    = slice_full[CHUNK-1:0];
    slice_cout = slice_full[CHUNK];
    // Carry into the slice MSB recovered from its sum bit and operand bits.
    msb_cin    = slice_s[CHUNK-1] ^ sa_q[CHUNK-1] ^ sb_q[CHUNK-1];
    slice_ovf  = msb_cin ^ slice_cout;
    res_shift  = (res_q >> CHUNK) | (WIDTH'(slice_s) << (WIDTH - CHUNK));
    final_sum  = res_shift;
`ifdef SEQ_ADDSUB_SAT_EN
    // Wrapped MSB set means the true result was positive, and vice versa.
    if (slice_ovf) begin
      final_sum = {~res_shift[WIDTH-1], {(WIDTH-1){res_shift[WIDTH-1]}}};
    end
`endif
  end

  // Next-state and datapath update for the three-state sequencer.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    c_d     = c_q;
    k_d     = k_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sa_d    = a;
          sb_d    = b ^ {WIDTH{sub}};
          c_d     = sub;
          k_d     = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sa_d  = sa_q >> CHUNK;
        sb_d  = sb_q >> CHUNK;
        res_d = res_shift;
        c_d   = slice_cout;
        k_d   = k_q + 1'b1;
        if (k_q == K_LAST) begin
          state_d = DONE;
          sum_d   = final_sum;
          carry_d = slice_cout;
          ovf_d   = slice_ovf;
          zero_d  = (final_sum == '0);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      k_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      c_q     <= c_d;
      k_q     <= k_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Testbench for seq_addsub: three instances (16/4, 8/8, 32/1) sharing one
// operand bus, checked against an arithmetic reference model.
module tb_seq_addsub;

  logic        clk;
  logic        rst;
  logic [2:0]  iv_v;
  logic [31:0] op_a, op_b;
  logic        op_sub;
  logic        out_ready;
  int          sel;

  logic        rdy0, rdy1, rdy2, ov0, ov1, ov2;
  logic [15:0] sum0;
  logic [7:0]  sum1;
  logic [31:0] sum2;
  logic        c0, c1, c2, f0, f1, f2, z0, z1, z2;

  logic [31:0] o_sum;
  logic        o_carry, o_ovf, o_zero, o_valid, o_ready;

  int n_vec = 0;
  int n_err = 0;
  int low_cnt;
  logic [31:0] last_sum;
  logic        last_c, last_o, last_z;

  seq_addsub #(.WIDTH(16), .CHUNK(4)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv_v[0]), .in_ready(rdy0),
    .a(op_a[15:0]), .b(op_b[15:0]), .sub(op_sub), .out_valid(ov0),
    .out_ready(out_ready), .sum(sum0), .carry(c0), .overflow(f0), .zero(z0));

  seq_addsub #(.WIDTH(8), .CHUNK(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv_v[1]), .in_ready(rdy1),
    .a(op_a[7:0]), .b(op_b[7:0]), .sub(op_sub), .out_valid(ov1),
    .out_ready(out_ready), .sum(sum1), .carry(c1), .overflow(f1), .zero(z1));

  seq_addsub #(.WIDTH(32), .CHUNK(1)) u32 (
    .clk(clk), .rst(rst), .in_valid(iv_v[2]), .in_ready(rdy2),
    .a(op_a), .b(op_b), .sub(op_sub), .out_valid(ov2),
    .out_ready(out_ready), .sum(sum2), .carry(c2), .overflow(f2), .zero(z2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    o_sum = 32'(sum0); o_carry = c0; o_ovf = f0; o_zero = z0; o_valid = ov0; o_ready = rdy0;
    case (sel)
      1: begin o_sum = 32'(sum1); o_carry = c1; o_ovf = f1; o_zero = z1; o_valid = ov1; o_ready = rdy1; end
      2: begin o_sum = sum2; o_carry = c2; o_ovf = f2; o_zero = z2; o_valid = ov2; o_ready = rdy2; end
      default: ;
    endcase
  end

  function automatic int width_of(input int s);
    return (s == 0) ? 16 : (s == 1) ? 8 : 32;
  endfunction

  function automatic int nch_of(input int s);
    return (s == 0) ? 4 : (s == 1) ? 1 : 32;
  endfunction

  // Reference: plain integer arithmetic plus sign-rule overflow detection.
  task automatic model(input int w, input longint unsigned a, input longint unsigned b,
                       input bit s, output longint unsigned es, output bit ec,
                       output bit eo, output bit ez);
    longint unsigned mask, r;
    bit sa, sb, ss;
    mask = (64'd1 << w) - 1;
    if (s) r = a + ((~b) & mask) + 1;
    else   r = a + b;
    ec = r[w];
    es = r & mask;
    sa = a[w-1]; sb = b[w-1]; ss = es[w-1];
    if (s) eo = (sa != sb) && (ss != sa);
    else   eo = (sa == sb) && (ss != sa);
`ifdef SEQ_ADDSUB_SAT_EN
    if (eo) es = sa ? (64'd1 << (w-1)) : (mask >> 1);
`endif
    ez = (es == 0);
  endtask

  // Issue one operation on instance s and check latency, busy and results.
  task automatic start_op(input int s, input logic [31:0] a, input logic [31:0] b,
                          input logic sb);
    longint unsigned es, mask;
    bit ec, eo, ez;
    int cnt;
    int w;
    w = width_of(s);
    mask = (64'd1 << w) - 1;
    sel = s;
    op_a = a & 32'(mask); op_b = b & 32'(mask); op_sub = sb;
    model(w, op_a, op_b, sb, es, ec, eo, ez);
    iv_v = 3'b000; iv_v[s] = 1'b1;
    @(posedge clk); #1;
    iv_v = 3'b000;
    op_a = $urandom; op_b = $urandom; op_sub = 1'($urandom);
    cnt = 0; low_cnt = 0;
    while (!o_valid && cnt < 200) begin
      if (!o_ready) low_cnt++;
      @(posedge clk); #1;
      cnt++;
    end
    if (!o_ready) low_cnt++;
    n_vec++;
    if (cnt !== nch_of(s)) begin
      n_err++;
      $display("FAIL latency w=%0d: got %0d edges, expected %0d", w, cnt, nch_of(s));
    end
    n_vec++;
    if (o_sum !== 32'(es) || o_carry !== ec || o_ovf !== eo || o_zero !== ez) begin
      n_err++;
      $display("FAIL result w=%0d a=%h b=%h sub=%0d: got sum=%h c=%b o=%b z=%b, expected sum=%h c=%b o=%b z=%b",
               w, a & 32'(mask), b & 32'(mask), sb, o_sum, o_carry, o_ovf, o_zero,
               32'(es), ec, eo, ez);
    end
    last_sum = o_sum; last_c = o_carry; last_o = o_ovf; last_z = o_zero;
  endtask

  task automatic release_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_vec++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_sum !== last_sum) begin
      n_err++;
      $display("FAIL handshake: got valid=%b ready=%b sum=%h, expected valid=0 ready=1 sum=%h",
               o_valid, o_ready, o_sum, last_sum);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({rdy0, rdy1, rdy2} !== 3'b111 || {ov0, ov1, ov2} !== 3'b000 ||
        sum0 !== 16'h0 || sum1 !== 8'h0 || sum2 !== 32'h0 ||
        {c0, c1, c2, f0, f1, f2, z0, z1, z2} !== 9'b0) begin
      n_err++;
      $display("FAIL reset: ready=%b valid=%b sums=%h/%h/%h flags=%b, expected ready=111 all else 0",
               {rdy0, rdy1, rdy2}, {ov0, ov1, ov2}, sum0, sum1, sum2,
               {c0, c1, c2, f0, f1, f2, z0, z1, z2});
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] ta [6], tb_ [6], tsum [6];
    logic        tsub [6], tc [6], to [6], tz [6];
    ta = '{32'h1234, 32'h0005, 32'h0007, 32'h7FFF, 32'h8000, 32'hFFFF};
    tb_ = '{32'h0FCD, 32'h0007, 32'h0007, 32'h0001, 32'h0001, 32'h0001};
    tsub = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
`ifdef SEQ_ADDSUB_SAT_EN
    tsum = '{32'h2201, 32'hFFFE, 32'h0000, 32'h7FFF, 32'h8000, 32'h0000};
`else
    tsum = '{32'h2201, 32'hFFFE, 32'h0000, 32'h8000, 32'h7FFF, 32'h0000};
`endif
    tc = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    to = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tz = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      start_op(0, ta[i], tb_[i], tsub[i]);
      n_vec++;
      if (last_sum !== tsum[i] || last_c !== tc[i] || last_o !== to[i] || last_z !== tz[i]) begin
        n_err++;
        $display("FAIL directed %0d: got sum=%h c=%b o=%b z=%b, expected sum=%h c=%b o=%b z=%b",
                 i, last_sum, last_c, last_o, last_z, tsum[i], tc[i], to[i], tz[i]);
      end
      release_op();
      if (i == 0) begin
        n_vec++;
        if (low_cnt !== 5) begin
          n_err++;
          $display("FAIL busy_cycles: in_ready low for %0d cycles, expected 5", low_cnt);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    start_op(0, 32'h4321, 32'h1111, 1'b0);
    iv_v[0] = 1'b1;
    op_a = 32'h0000_0001; op_b = 32'h0000_0001; op_sub = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_sum !== last_sum ||
          o_carry !== last_c || o_ovf !== last_o || o_zero !== last_z) begin
        n_err++;
        $display("FAIL backpressure cycle %0d: got valid=%b ready=%b sum=%h, expected valid=1 ready=0 sum=%h",
                 i, o_valid, o_ready, o_sum, last_sum);
      end
    end
    iv_v = 3'b000;
    release_op();
    start_op(0, 32'h0100, 32'h0200, 1'b1);
    release_op();
  endtask

  task automatic test_reset_mid_op();
    sel = 0;
    op_a = 32'h1234; op_b = 32'h5678; op_sub = 1'b0;
    iv_v = 3'b001;
    @(posedge clk); #1;
    iv_v = 3'b000;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_sum !== 32'h0) begin
      n_err++;
      $display("FAIL reset_mid_op: got ready=%b valid=%b sum=%h, expected ready=1 valid=0 sum=0",
               o_ready, o_valid, o_sum);
    end
    start_op(0, 32'hFFFF, 32'h0001, 1'b0);
    n_vec++;
    if (last_sum !== 32'h0 || last_c !== 1'b1 || last_z !== 1'b1) begin
      n_err++;
      $display("FAIL after_reset_op: got sum=%h c=%b z=%b, expected sum=0 c=1 z=1",
               last_sum, last_c, last_z);
    end
    release_op();
  endtask

  task automatic test_random(input int s, input int n);
    for (int i = 0; i < n; i++) begin
      start_op(s, $urandom, $urandom, 1'($urandom));
      release_op();
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      start_op(1, $urandom, $urandom, 1'($urandom));
      release_op();
    end
  endtask

  initial begin
    rst = 1'b1; iv_v = 3'b000; op_a = '0; op_b = '0; op_sub = 1'b0;
    out_ready = 1'b0; sel = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_op();
    test_random(0, 30);
    test_random(1, 30);
    test_random(2, 12);
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
